// File: rtl/frame_capture_ctrl_if.sv
// Bundles the camera byte stream, capture controls and frame-buffer write port of frame_capture_ctrl.
// master = the capture controller, slave = camera/top-level side that drives it.
interface frame_capture_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic              start;
    logic              cont;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;
    logic              w_en;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              busy;
    logic              frame_done;
    logic              short_frame;

    modport master (
        input  vsync, href, d, start, cont,
        output w_addr, w_data, w_en, x, y, busy, frame_done, short_frame
    );

    modport slave (
        output vsync, href, d, start, cont,
        input  w_addr, w_data, w_en, x, y, busy, frame_done, short_frame
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Captures one RGB565 camera frame (VSYNC/HREF framing) into a WIDTH x HEIGHT RGB332 frame buffer.
// Define CAPTURE_TEST_PATTERN_EN to replace camera pixels with colour bars selected by x[7:5].
module frame_capture_ctrl #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_capture_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_VBLANK,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [9:0]        COORD_MAX = '1;
    localparam logic [9:0]        WIDTH_X   = 10'(WIDTH);
    localparam logic [9:0]        HEIGHT_Y  = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);

    state_t            state;
    logic              phase;       // 0 = expecting high byte, 1 = low byte
    logic [5:0]        hi_bits;     // only the high-byte bits that survive RGB332 packing
    logic              href_q;
    logic [ADDR_W-1:0] addr_ptr;    // address of the next stored pixel on this line
    logic [ADDR_W-1:0] line_base;   // address of pixel 0 of the current line

    logic       in_window;
    logic [7:0] pix_data;

`ifdef CAPTURE_TEST_PATTERN_EN
    function automatic logic [7:0] bar_colour(input logic [2:0] sel);
        case (sel)
            3'd0:    return 8'hE0;
            3'd1:    return 8'h1C;
            3'd2:    return 8'h03;
            3'd3:    return 8'hFF;
            3'd4:    return 8'h00;
            3'd5:    return 8'hE0;
            3'd6:    return 8'h1C;
            default: return 8'h03;
        endcase
    endfunction
`endif

    always_comb begin
        in_window = (bus.x < WIDTH_X) && (bus.y < HEIGHT_Y);
`ifdef CAPTURE_TEST_PATTERN_EN
        pix_data  = bar_colour(bus.x[7:5]);
`else
        pix_data  = {hi_bits, bus.d[4:3]};
`endif
    end

    // NOTE: all state below is non-blocking so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            phase           <= 1'b0;
            hi_bits         <= '0;
            href_q          <= 1'b0;
            addr_ptr        <= '0;
            line_base       <= '0;
            bus.w_addr      <= '0;
            bus.w_data      <= '0;
            bus.w_en        <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.busy        <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.short_frame <= 1'b0;
        end else begin
            // Strobes default low so each assertion below lasts exactly one cycle.
            bus.w_en       <= 1'b0;
            bus.frame_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start || bus.cont) begin
                        state    <= S_ARM;
                        bus.busy <= 1'b1;
                    end
                end

                S_ARM: begin
                    if (bus.vsync) state <= S_VBLANK;
                end

                S_VBLANK: begin
                    if (!bus.vsync) begin
                        state      <= S_CAPTURE;
                        phase      <= 1'b0;
                        href_q     <= 1'b0;
                        addr_ptr   <= '0;
                        line_base  <= '0;
                        bus.w_addr <= '0;
                        bus.x      <= '0;
                        bus.y      <= '0;
                    end
                end

                S_CAPTURE: begin
                    href_q <= bus.href;
                    if (bus.vsync) begin
                        // Frame end wins over any byte arriving on the same edge.
                        state           <= S_DONE;
                        bus.frame_done  <= 1'b1;
                        bus.short_frame <= (bus.y < HEIGHT_Y);
                        bus.busy        <= 1'b0;
                    end else if (bus.href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi_bits <= {bus.d[7:5], bus.d[2:0]};
                        end else begin
                            if (in_window) begin
                                bus.w_data <= pix_data;
                                bus.w_addr <= addr_ptr;
                                bus.w_en   <= 1'b1;
                                addr_ptr   <= addr_ptr + 1'b1;
                            end
                            if (bus.x != COORD_MAX) bus.x <= bus.x + 10'd1;
                        end
                    end else if (href_q) begin
                        // Line end: a dangling high byte is dropped by clearing the phase.
                        phase <= 1'b0;
                        bus.x <= '0;
                        if (bus.y != COORD_MAX) bus.y <= bus.y + 10'd1;
                        if (bus.y < HEIGHT_Y) begin
                            line_base <= line_base + WIDTH_A;
                            addr_ptr  <= line_base + WIDTH_A;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.cont) begin
                        state    <= S_ARM;
                        bus.busy <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: a FIFO of expected (address, pixel) pairs built from the
// bytes the bench sends, plus hand-computed counts for frame framing and boundary cases.
module tb_frame_capture_ctrl;
    localparam int W = 176;
    localparam int H = 144;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_capture_ctrl_if #(.ADDR_W(15)) bus ();

    frame_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_head;
    int          wr_cnt, wr_bad, fd_cnt, line_no;
    logic [14:0] last_addr, max_addr;
    logic [7:0]  last_data, data_at0, data_at32, data_at64;
    logic        sf_seen, busy_at_fd;

    // Write-port monitor, sampling on the falling edge away from the DUT's active edge.
    always @(negedge clk) begin
        if (bus.w_en) begin
            wr_cnt++;
            last_addr = bus.w_addr;
            last_data = bus.w_data;
            if (bus.w_addr > max_addr) max_addr = bus.w_addr;
            if (bus.w_addr == 15'd0)  data_at0  = bus.w_data;
            if (bus.w_addr == 15'd32) data_at32 = bus.w_data;
            if (bus.w_addr == 15'd64) data_at64 = bus.w_data;
            if (exp_q.size() == 0) begin
                wr_bad++;
            end else begin
                exp_head = exp_q.pop_front();
                if (exp_head.addr !== bus.w_addr || exp_head.data !== bus.w_data) wr_bad++;
            end
        end
        if (bus.frame_done) begin
            fd_cnt++;
            sf_seen    = bus.short_frame;
            busy_at_fd = bus.busy;
        end
    end

    function automatic logic [7:0] byte_at(input logic fixed, input logic [7:0] seed, input int k);
        if (fixed) return (k % 2 == 0) ? 8'hF8 : 8'h00;
        return seed + 8'(k * 37);
    endfunction

    function automatic logic [7:0] pix_cam(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    function automatic logic [7:0] pix_bar(input int px);
        case ((px / 32) % 8)
            0:       return 8'hE0;
            1:       return 8'h1C;
            2:       return 8'h03;
            3:       return 8'hFF;
            4:       return 8'h00;
            5:       return 8'hE0;
            6:       return 8'h1C;
            default: return 8'h03;
        endcase
    endfunction

    task automatic clear_stats();
        wr_cnt   = 0;
        wr_bad   = 0;
        fd_cnt   = 0;
        max_addr = '0;
        exp_q.delete();
    endtask

    // Sends nbytes with HREF high; model=1 queues the writes that must appear.
    // cut=1 raises VSYNC while HREF is still high instead of closing the line normally.
    task automatic send_line(input int nbytes, input logic fixed, input logic [7:0] seed,
                             input bit model, input bit cut);
        logic [7:0] hi;
        logic [7:0] pix;
        int         px;
        hi = '0;
        px = 0;
        for (int k = 0; k < nbytes; k++) begin
            @(negedge clk);
            bus.href = 1'b1;
            bus.d    = byte_at(fixed, seed, k);
            if (k % 2 == 0) begin
                hi = bus.d;
            end else begin
`ifdef CAPTURE_TEST_PATTERN_EN
                pix = pix_bar(px);
`else
                pix = pix_cam(hi, bus.d);
`endif
                if (model && line_no < H && px < W)
                    exp_q.push_back('{addr: 15'(line_no * W + px), data: pix});
                px++;
            end
        end
        if (cut) begin
            @(negedge clk);
            bus.vsync = 1'b1;
            bus.d     = 8'h5A;
        end
        @(negedge clk);
        bus.href = 1'b0;
        bus.d    = '0;
        @(negedge clk);
        line_no++;
    endtask

    // Vertical blank with HREF chatter that must be ignored, then the VSYNC fall.
    task automatic frame_start();
        @(negedge clk);
        bus.vsync = 1'b1;
        bus.href  = 1'b1;
        bus.d     = 8'hA5;
        repeat (2) @(negedge clk);
        bus.href = 1'b0;
        @(negedge clk);
        bus.vsync = 1'b0;
        repeat (3) @(negedge clk);
        line_no = 0;
    endtask

    task automatic frame_end();
        @(negedge clk);
        bus.vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    int wr_before;

    initial begin
        bus.vsync = 1'b0;
        bus.href  = 1'b0;
        bus.d     = '0;
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        line_no   = 0;
        clear_stats();
        repeat (3) @(negedge clk);

        check("rst_w_en",        32'(bus.w_en), 0);
        check("rst_busy",        32'(bus.busy), 0);
        check("rst_frame_done",  32'(bus.frame_done), 0);
        check("rst_short_frame", 32'(bus.short_frame), 0);
        check("rst_w_addr",      32'(bus.w_addr), 0);
        check("rst_w_data",      32'(bus.w_data), 0);
        check("rst_x",           32'(bus.x), 0);
        check("rst_y",           32'(bus.y), 0);
        rst_n = 1'b1;

        // Full frame that also overruns both edges: 148 lines of 180 pixels (F8/00 -> E0).
        bus.start = 1'b1;
        frame_start();
        bus.start = 1'b0;
        check("full_busy_in_capture", 32'(bus.busy), 1);
        for (int l = 0; l < H + 4; l++) send_line(360, 1'b1, 8'h00, 1'b1, 1'b0);
        check("full_y_after_lines", 32'(bus.y), 148);
        frame_end();
        check("full_write_count", 32'(wr_cnt), 25344);
        check("full_write_errors", 32'(wr_bad), 0);
        check("full_missing_writes", 32'(exp_q.size()), 0);
        check("full_last_addr", 32'(last_addr), 25343);
        check("full_max_addr", 32'(max_addr), 25343);
        check("full_last_data", 32'(last_data), 32'h00E0);
        check("full_frame_done_once", 32'(fd_cnt), 1);
        check("full_short_frame", 32'(sf_seen), 0);
        check("full_busy_at_done", 32'(busy_at_fd), 0);
`ifdef CAPTURE_TEST_PATTERN_EN
        check("bar_x0", 32'(data_at0), 32'h00E0);
        check("bar_x32", 32'(data_at32), 32'h001C);
        check("bar_x64", 32'(data_at64), 32'h0003);
`else
        check("pix_x0", 32'(data_at0), 32'h00E0);
        check("pix_x32", 32'(data_at32), 32'h00E0);
        check("pix_x64", 32'(data_at64), 32'h00E0);
`endif
        repeat (3) @(negedge clk);
        check("idle_after_done", 32'(bus.busy), 0);

        // Reset mid-capture, landing on the edge that takes a pixel's low byte.
        clear_stats();
        bus.start = 1'b1;
        frame_start();
        bus.start = 1'b0;
        send_line(16, 1'b0, 8'h31, 1'b1, 1'b0);
        send_line(16, 1'b0, 8'h52, 1'b1, 1'b0);
        send_line(2, 1'b0, 8'h13, 1'b1, 1'b0);
        @(negedge clk);
        bus.href = 1'b1;
        bus.d    = 8'hC3;
        @(negedge clk);
        bus.d = 8'h18;
        rst_n = 1'b0;
        @(negedge clk);
        bus.href = 1'b0;
        bus.d    = '0;
        @(negedge clk);
        check("mid_rst_w_en", 32'(bus.w_en), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_x", 32'(bus.x), 0);
        check("mid_rst_y", 32'(bus.y), 0);
        check("mid_rst_w_addr", 32'(bus.w_addr), 0);
        check("mid_rst_w_data", 32'(bus.w_data), 0);
        check("pre_rst_writes", 32'(wr_cnt), 17);
        check("pre_rst_write_errors", 32'(wr_bad), 0);
        rst_n = 1'b1;
        wr_before = wr_cnt;
        repeat (5) @(negedge clk);
        check("post_rst_idle_busy", 32'(bus.busy), 0);
        check("post_rst_no_write", 32'(wr_cnt - wr_before), 0);

        // START while VSYNC is already low: nothing before the next VSYNC fall.
        clear_stats();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        line_no = 0;
        for (int l = 0; l < 3; l++) send_line(20, 1'b0, 8'(l * 9), 1'b0, 1'b0);
        check("midframe_no_writes", 32'(wr_cnt), 0);
        check("midframe_busy_armed", 32'(bus.busy), 1);
        frame_start();
        send_line(20, 1'b0, 8'h0B, 1'b1, 1'b0);
        send_line(7, 1'b0, 8'h28, 1'b1, 1'b0);
        send_line(20, 1'b0, 8'h4D, 1'b1, 1'b0);
        frame_end();
        check("midframe_write_count", 32'(wr_cnt), 23);
        check("midframe_write_errors", 32'(wr_bad), 0);
        check("midframe_missing_writes", 32'(exp_q.size()), 0);
        check("midframe_done_once", 32'(fd_cnt), 1);
        check("midframe_short_frame", 32'(sf_seen), 1);

        // Continuous mode: a 100-line frame, then a frame cut by VSYNC mid-line.
        clear_stats();
        bus.cont = 1'b1;
        frame_start();
        for (int l = 0; l < 100; l++) send_line(16, 1'b0, 8'(l * 3 + 1), 1'b1, 1'b0);
        frame_end();
        check("cont_frame_done", 32'(fd_cnt), 1);
        check("cont_short_frame", 32'(sf_seen), 1);
        check("cont_busy_low_at_done", 32'(busy_at_fd), 0);
        check("cont_busy_rearmed", 32'(bus.busy), 1);
        check("cont_write_count", 32'(wr_cnt), 800);
        frame_start();
        send_line(16, 1'b0, 8'h66, 1'b1, 1'b0);
        bus.cont = 1'b0;
        send_line(5, 1'b0, 8'h77, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("cut_frame_done_total", 32'(fd_cnt), 2);
        check("cut_short_frame", 32'(sf_seen), 1);
        check("cut_write_count", 32'(wr_cnt), 810);
        check("cut_write_errors", 32'(wr_bad), 0);
        check("cut_missing_writes", 32'(exp_q.size()), 0);
        check("cut_idle_busy", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
